// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad FSM states, one-hot column/row constants and helpers
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_e;

  localparam logic [3:0] COL0 = 4'b0001;
  localparam logic [3:0] COL1 = 4'b0010;
  localparam logic [3:0] COL2 = 4'b0100;
  localparam logic [3:0] COL3 = 4'b1000;
  localparam logic [3:0] ROW0 = 4'b0001;
  localparam logic [3:0] ROW1 = 4'b0010;
  localparam logic [3:0] ROW2 = 4'b0100;
  localparam logic [3:0] ROW3 = 4'b1000;

  function automatic logic [3:0] next_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with press/release debounce
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_COUNT = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_in,
  output logic [3:0] col_drive,
  output logic [3:0] key_cols,
  output logic [3:0] key_rows,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DWW = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_COUNT);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_COUNT - 1);

  logic [3:0]     rows_s;
  state_e         state;
  logic [DWW-1:0] dwell_cnt;
  logic [DBW-1:0] deb_cnt;
  logic [3:0]     cap_rows;
  logic [3:0]     cap_cols;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows_in),
    .q     (rows_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_SCAN;
      col_drive <= COL0;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      cap_rows  <= '0;
      cap_cols  <= '0;
      key_cols  <= '0;
      key_rows  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          // rows are only trusted at the end of the dwell, once the column has settled
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (is_onehot4(rows_s)) begin
              cap_rows <= rows_s;
              cap_cols <= col_drive;
              deb_cnt  <= '0;
              state    <= ST_PRESS_DB;
            end else begin
              col_drive <= next_col(col_drive);
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end

        ST_PRESS_DB: begin
          if (rows_s != cap_rows) begin
            col_drive <= next_col(col_drive);
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            state     <= ST_SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            key_cols  <= cap_cols;
            key_rows  <= cap_rows;
            key_down  <= 1'b1;
            key_valid <= 1'b1;
            deb_cnt   <= '0;
            state     <= ST_PRESSED;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        ST_PRESSED: begin
          // a second key joining the held one is deliberately ignored
          if (rows_s == 4'b0000) begin
            deb_cnt <= '0;
            state   <= ST_RELEASE_DB;
          end
        end

        ST_RELEASE_DB: begin
          if (rows_s != 4'b0000) begin
            deb_cnt <= '0;
            state   <= ST_PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            key_cols  <= '0;
            key_rows  <= '0;
            key_down  <= 1'b0;
            col_drive <= next_col(col_drive);
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            state     <= ST_SCAN;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a 4x4 keypad model
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows_in;
  logic [3:0] col_drive, key_cols, key_rows;
  logic       key_valid, key_down;

  logic [3:0] press_col = 4'b0000;
  logic [3:0] press_rows = 4'b0000;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  logic [7:0] exp_q[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_COUNT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows_in   (rows_in),
    .col_drive (col_drive),
    .key_cols  (key_cols),
    .key_rows  (key_rows),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // the pressed key connects its column drive to its row lines
  assign rows_in = ((col_drive & press_col) != 4'b0000) ? press_rows : 4'b0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("out_consistency",
            {31'd0 | {key_cols != 4'b0, key_rows != 4'b0,
                      $countones(key_cols) <= 1, $countones(key_rows) <= 1}},
            {28'd0, key_down, key_down, 1'b1, 1'b1});
      if (key_valid) begin
        valid_cnt++;
        valid_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("valid_key", {key_cols, key_rows}, exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_key_down(input logic lvl, input int bound, input string tag);
    int k;
    for (k = 0; k < bound && key_down !== lvl; k++) @(negedge clk);
    if (key_down !== lvl) check(tag, 0, 1);
  endtask

  task automatic wait_valid(input int target, input int bound, input string tag);
    int k;
    for (k = 0; k < bound && valid_cnt < target; k++) @(negedge clk);
    check(tag, valid_cnt, target);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_col"}, col_drive, COL0);
    check({tag, "_cols"}, key_cols, 4'b0000);
    check({tag, "_rows"}, key_rows, 4'b0000);
    check({tag, "_valid"}, key_valid, 1'b0);
    check({tag, "_down"}, key_down, 1'b0);
  endtask

  initial begin
    int base, s, k;
    logic [3:0] one, c1, c2;
    one = 4'b0001;

    // reset state
    cycles(3);
    check_reset_outs("reset");
    reset = 1'b0;

    // idle rotation: sync to the first step, then each column holds for 4 cycles
    for (k = 0; k < 20 && col_drive == COL0; k++) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      check("idle_rotate", col_drive, one << ((i / 4 + 1) % 4));
    end

    // key '5' held 200 cycles
    base = valid_cnt;
    exp_q.push_back({COL1, ROW1});
    press_col = COL1;
    press_rows = ROW1;
    cycles(200);
    check("k5_one_valid", valid_cnt, base + 1);
    check("k5_down", key_down, 1'b1);
    check("k5_cols", key_cols, COL1);
    check("k5_rows", key_rows, ROW1);
    check("k5_col_frozen", col_drive, COL1);

    // release '5' with a 4-cycle glitch back to pressed
    base = valid_cnt;
    press_rows = 4'b0000;
    cycles(5);
    press_rows = ROW1;
    cycles(4);
    press_rows = 4'b0000;
    check("glitch_hold_down", key_down, 1'b1);
    wait_key_down(1'b0, 60, "k5_release_timeout");
    check("k5_rel_col_resume", col_drive, COL2);
    check("k5_rel_cols", key_cols, 4'b0000);
    check("k5_rel_rows", key_rows, 4'b0000);
    check("k5_rel_no_valid", valid_cnt, base);

    // key 'D' with bouncing rows
    base = valid_cnt;
    exp_q.push_back({COL3, ROW3});
    press_col = COL3;
    for (int b = 0; b < 10; b++) begin
      press_rows = (b % 2 == 0) ? ROW3 : 4'b0000;
      cycles(3);
    end
    check("bounce_no_valid", valid_cnt, base);
    s = cyc;
    press_rows = ROW3;
    wait_valid(base + 1, 100, "kD_valid");
    check("kD_latency_ge11", (valid_cyc - s) >= 11, 1);
    check("kD_cols", key_cols, COL3);
    check("kD_rows", key_rows, ROW3);
    press_rows = 4'b0000;
    wait_key_down(1'b0, 60, "kD_release_timeout");

    // keys '1' and '4' together: ghost, rejected
    base = valid_cnt;
    press_col = COL0;
    press_rows = ROW0 | ROW1;
    cycles(100);
    check("ghost_no_valid", valid_cnt, base);
    check("ghost_not_down", key_down, 1'b0);
    c1 = col_drive;
    cycles(4);
    c2 = col_drive;
    check("ghost_rotating", c2, {c1[2:0], c1[3]});
    press_rows = 4'b0000;
    cycles(10);

    // reset during press debounce at count 5
    base = valid_cnt;
    press_col = COL1;
    press_rows = ROW1;
    for (k = 0; k < 100 && !(dut.state == ST_PRESS_DB && dut.deb_cnt == 3'd5); k++) @(negedge clk);
    check("pdb_reach", (dut.state == ST_PRESS_DB) && (dut.deb_cnt == 3'd5), 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outs("midreset");
    check("midreset_no_valid", valid_cnt, base);
    cycles(2);
    exp_q.push_back({COL1, ROW1});
    s = cyc;
    reset = 1'b0;
    wait_valid(base + 1, 200, "post_reset_valid");
    check("post_reset_latency_ge11", (valid_cyc - s) >= 11, 1);
    press_rows = 4'b0000;
    wait_key_down(1'b0, 60, "final_release_timeout");

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each column is driven while scanning (minimum 4).
REQ-002 Parameter DEBOUNCE_COUNT, default 20000: consecutive stable synchronized samples required to accept a press or a release (minimum 2).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rows_in  input  4  raw keypad row pins; active-high, externally pulled down, asynchronous to clk.
REQ-006 col_drive  output  4  one-hot column drive to keypad pins 1-4; bit0 = column of keys 1/4/7/*.
REQ-007 key_cols  output  4  one-hot column of the accepted key; held while key_down; feeds the downstream encoder's columns port.
REQ-008 key_rows  output  4  one-hot row of the accepted key; held while key_down; feeds the downstream encoder's rows port.
REQ-009 key_valid  output  1  single-cycle strobe on press acceptance.
REQ-010 key_down  output  1  level; high from press acceptance until release acceptance.

Function
REQ-011 rows_in shall pass through a two-flop synchronizer; only the synchronized value (rows_s) is used, giving 2 cycles of input latency.
REQ-012 FSM states shall be SCAN, PRESS_DB, PRESSED and RELEASE_DB.
REQ-013 In SCAN, a dwell counter shall count 0..SCAN_DIV-1, and col_drive shall rotate 0001->0010->0100->1000->0001 on the cycle after count SCAN_DIV-1.
REQ-014 In SCAN, rows_s shall be evaluated only on the last dwell cycle (count SCAN_DIV-1), so it has settled for at least SCAN_DIV-3 cycles.
REQ-015 At that evaluation, if rows_s is exactly one-hot, the FSM shall capture rows_s and col_drive internally, freeze col_drive, and enter PRESS_DB with debounce counter 0.
REQ-016 At that evaluation, if rows_s is zero or multi-hot (ghost/multi-key), the FSM shall stay in SCAN and rotate col_drive.
REQ-017 In PRESS_DB, the counter shall increment each cycle rows_s equals the captured rows.
REQ-018 In PRESS_DB, any mismatch shall return the FSM to SCAN with the column advanced, dwell counter 0, and no outputs changed.
REQ-019 When the PRESS_DB counter reaches DEBOUNCE_COUNT-1 with a match, the next cycle shall enter PRESSED, load key_cols/key_rows from the captures, set key_down=1 and pulse key_valid=1 for exactly that one cycle.
REQ-020 In PRESSED, col_drive shall stay frozen, and rows_s==0 shall enter RELEASE_DB with counter 0.
REQ-021 In PRESSED, any other rows_s value (including an added second key) shall be ignored.
REQ-022 In RELEASE_DB, the counter shall increment while rows_s==0, and any nonzero rows_s shall return the FSM to PRESSED with no new key_valid.
REQ-023 When the RELEASE_DB counter reaches DEBOUNCE_COUNT-1, the next cycle shall enter SCAN, clear key_down, key_cols and key_rows to 0, and resume scanning at the column after the released one.
REQ-024 Holding a key shall produce exactly one key_valid; a new key_valid shall require a full release acceptance first.
REQ-025 key_cols and key_rows shall both be 0 or both be one-hot, and shall be one-hot exactly when key_down=1.
REQ-026 Dwell and debounce counters shall be sized $clog2 of their parameter and shall never wrap; they reset to 0 on every state change.

Reset
REQ-027 While reset is high at a clock edge: state=SCAN, col_drive=4'b0001, key_cols=0, key_rows=0, key_valid=0, key_down=0, counters=0, synchronizer flops=0.
REQ-028 Reset asserted in any state, including mid-debounce or PRESSED, shall abort without emitting key_valid; the first key_valid after reset shall require a full fresh debounce.

Structure
REQ-029 Shared package keypad_pkg shall hold the FSM state enum and the one-hot constants COL0..COL3/ROW0..ROW3, also used by the downstream encoder.
REQ-030 The two-flop synchronizer shall be the sub-module sync_2ff (parameterized width 4); all other logic shall be in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_COUNT=8, keypad model: row r high when col_drive selects pressed key's column)
REQ-031 Reset release, no key -> col_drive cycles 0001,0010,0100,1000 every 4 cycles; key_valid never asserts.
REQ-032 Press key '5' (col 0010, row 0010) held 200 cycles -> exactly one key_valid; key_cols=0010, key_rows=0010, key_down=1; col_drive frozen at 0010.
REQ-033 Press 'D' with rows bouncing (toggle every 3 cycles for 30 cycles, then stable) -> single key_valid only after 8 stable samples; key_cols=1000, key_rows=1000.
REQ-034 Release '5' with a 4-cycle glitch back to pressed at release cycle 5 -> key_down stays 1, no second key_valid; after 8 clean zero samples key_down=0, outputs 0, scanning resumes at col 0100.
REQ-035 Keys '1' and '4' pressed together (col 0001, rows 0011) -> no key_valid; scanner keeps rotating.
REQ-036 Assert reset during PRESS_DB at count 5 -> next cycle all outputs at reset values; no key_valid observed.
